// File: rtl/rob_commit_ctrl.sv
// rob_commit_ctrl: in-order retirement sequencer for the reorder buffer.
//
// Each round it scans the oldest ROB entries starting at the retire pointer.
// It plans up to MAX_RETIRE consecutive finished entries, then drives them
// onto a multi-port register-file write interface. It advances the retire
// pointer once the register file accepts the group.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   rob_finished  finished bit per ROB entry
//   rob_values    result per entry, entry i at [i*DATA_W +: DATA_W]
//   rob_targets   destination register per entry, entry i at [i*REG_W +: REG_W]
//   rob_count     number of allocated, unretired entries (0..ENTRIES)
//   flush_valid   discard the plan and reload the retire pointer from flush_ptr
//   flush_ptr     retire pointer value loaded on flush
//   rf_ready      register file accepts the presented write group this cycle
//   rf_we         per-port write enable (port 0 = oldest entry)
//   rf_waddr      per-port destination register
//   rf_wdata      per-port write data
//   retire_valid  group committed this cycle
//   retire_count  entries committed this cycle
//   retire_ptr    oldest unretired entry (ROB tail)
module rob_commit_ctrl #(
  parameter int ENTRIES    = 16,
  parameter int IDX_W      = 4,
  parameter int DATA_W     = 16,
  parameter int REG_W      = 4,
  parameter int MAX_RETIRE = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ENTRIES-1:0]           rob_finished,
  input  logic [ENTRIES*DATA_W-1:0]    rob_values,
  input  logic [ENTRIES*REG_W-1:0]     rob_targets,
  input  logic [IDX_W:0]               rob_count,
  input  logic                         flush_valid,
  input  logic [IDX_W-1:0]             flush_ptr,
  input  logic                         rf_ready,
  output logic [MAX_RETIRE-1:0]        rf_we,
  output logic [MAX_RETIRE*REG_W-1:0]  rf_waddr,
  output logic [MAX_RETIRE*DATA_W-1:0] rf_wdata,
  output logic                         retire_valid,
  output logic [2:0]                   retire_count,
  output logic [IDX_W-1:0]             retire_ptr
);

  typedef enum logic {SCAN = 1'b0, COMMIT = 1'b1} state_t;

  state_t                       state_r;
  state_t                       state_next_s;
  logic [IDX_W-1:0]             ptr_r;

  // Registered plan for the group currently being committed.
  logic [2:0]                   n_r;
  logic [MAX_RETIRE-1:0]        we_r;
  logic [MAX_RETIRE*REG_W-1:0]  waddr_r;
  logic [MAX_RETIRE*DATA_W-1:0] wdata_r;

  // Combinational scan results.
  logic [IDX_W-1:0]             scan_idx_s [MAX_RETIRE];
  logic [2:0]                   scan_n_s;
  logic                         scan_run_s;
  logic [MAX_RETIRE-1:0]        scan_base_we_s;
  logic [MAX_RETIRE-1:0]        scan_we_s;
  logic [MAX_RETIRE*REG_W-1:0]  scan_waddr_s;
  logic [MAX_RETIRE*DATA_W-1:0] scan_wdata_s;
  logic                         commit_fire_s;

  // Length of the finished run at the retire pointer, clamped by rob_count.
  always_comb begin
    scan_run_s = 1'b1;
    scan_n_s   = 3'd0;
    for (int k = 0; k < MAX_RETIRE; k++) begin
      // The IDX_W-bit add wraps naturally modulo ENTRIES.
      scan_idx_s[k] = ptr_r + IDX_W'(k);
      scan_run_s    = scan_run_s & rob_finished[scan_idx_s[k]];
      if (scan_run_s && ((IDX_W+1)'(k) < rob_count)) begin
        scan_n_s = 3'(k + 1);
      end else begin
        scan_n_s = scan_n_s;
      end
    end
  end

  // Gather the targets and data of the planned entries and mask older writes
  // that a younger entry in the same group overwrites.
  always_comb begin
    scan_waddr_s   = '0;
    scan_wdata_s   = '0;
    scan_base_we_s = '0;
    for (int k = 0; k < MAX_RETIRE; k++) begin
      if (3'(k) < scan_n_s) begin
        scan_base_we_s[k]               = 1'b1;
        scan_waddr_s[k*REG_W +: REG_W]   = rob_targets[scan_idx_s[k]*REG_W +: REG_W];
        scan_wdata_s[k*DATA_W +: DATA_W] = rob_values[scan_idx_s[k]*DATA_W +: DATA_W];
      end else begin
        scan_base_we_s[k] = 1'b0;
      end
    end
    scan_we_s = scan_base_we_s;
    for (int j = 0; j < MAX_RETIRE; j++) begin
      for (int k = j + 1; k < MAX_RETIRE; k++) begin
        if (scan_base_we_s[j] && scan_base_we_s[k] &&
            (scan_waddr_s[j*REG_W +: REG_W] == scan_waddr_s[k*REG_W +: REG_W])) begin
          scan_we_s[j] = 1'b0;
        end else begin
          scan_we_s[j] = scan_we_s[j];
        end
      end
    end
  end

  // State and retire pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= SCAN;
      ptr_r   <= '0;
    end else if (flush_valid) begin
      state_r <= SCAN;
      ptr_r   <= flush_ptr;
    end else begin
      state_r <= state_next_s;
      if (state_r == COMMIT && rf_ready) begin
        ptr_r <= ptr_r + IDX_W'(n_r);
      end else begin
        ptr_r <= ptr_r;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      SCAN: begin
        if (scan_n_s != 3'd0) begin
          state_next_s = COMMIT;
        end else begin
          state_next_s = SCAN;
        end
      end
      COMMIT: begin
        if (rf_ready) begin
          state_next_s = SCAN;
        end else begin
          state_next_s = COMMIT;
        end
      end
      default: state_next_s = SCAN;
    endcase
  end

  // Plan registers: loaded in SCAN, held through stalls, cleared once the
  // group retires or is discarded so idle cycles present no write.
  always_ff @(posedge clk) begin
    if (rst || flush_valid) begin
      n_r     <= 3'd0;
      we_r    <= '0;
      waddr_r <= '0;
      wdata_r <= '0;
    end else if (state_r == SCAN && scan_n_s != 3'd0) begin
      n_r     <= scan_n_s;
      we_r    <= scan_we_s;
      waddr_r <= scan_waddr_s;
      wdata_r <= scan_wdata_s;
    end else if (state_r == COMMIT && rf_ready) begin
      n_r     <= 3'd0;
      we_r    <= '0;
      waddr_r <= '0;
      wdata_r <= '0;
    end else begin
      n_r     <= n_r;
      we_r    <= we_r;
      waddr_r <= waddr_r;
      wdata_r <= wdata_r;
    end
  end

  // Outputs: handshake report and write-enable suppression during a flush
  // or reset cycle.
  always_comb begin
    commit_fire_s = (state_r == COMMIT) && rf_ready && !flush_valid && !rst;
    retire_valid  = commit_fire_s;
    if (commit_fire_s) begin
      retire_count = n_r;
    end else begin
      retire_count = 3'd0;
    end
    if (flush_valid || rst) begin
      rf_we = '0;
    end else begin
      rf_we = we_r;
    end
  end

  assign rf_waddr   = waddr_r;
  assign rf_wdata   = wdata_r;
  assign retire_ptr = ptr_r;

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Self-checking bench for rob_commit_ctrl: a table of hand-derived vectors
// for the directed sequences, then random traffic compared against a
// behavioural model of the retirement rules.
module tb_rob_commit_ctrl;
  localparam int ENTRIES = 16;
  localparam int IDX_W = 4;
  localparam int DATA_W = 16;
  localparam int REG_W = 4;
  localparam int MR = 3;

  logic                    clk;
  logic                    rst;
  logic [ENTRIES-1:0]      rob_finished;
  logic [ENTRIES*DATA_W-1:0] rob_values;
  logic [ENTRIES*REG_W-1:0]  rob_targets;
  logic [IDX_W:0]          rob_count;
  logic                    flush_valid;
  logic [IDX_W-1:0]        flush_ptr;
  logic                    rf_ready;
  logic [MR-1:0]           rf_we;
  logic [MR*REG_W-1:0]     rf_waddr;
  logic [MR*DATA_W-1:0]    rf_wdata;
  logic                    retire_valid;
  logic [2:0]              retire_count;
  logic [IDX_W-1:0]        retire_ptr;

  rob_commit_ctrl #(
    .ENTRIES(ENTRIES), .IDX_W(IDX_W), .DATA_W(DATA_W), .REG_W(REG_W), .MAX_RETIRE(MR)
  ) dut (
    .clk(clk), .rst(rst), .rob_finished(rob_finished), .rob_values(rob_values),
    .rob_targets(rob_targets), .rob_count(rob_count), .flush_valid(flush_valid),
    .flush_ptr(flush_ptr), .rf_ready(rf_ready), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .retire_valid(retire_valid), .retire_count(retire_count),
    .retire_ptr(retire_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [DATA_W-1:0] val [ENTRIES];
  logic [REG_W-1:0]  tgt [ENTRIES];

  // Reference model: retire pointer plus an optional pending group.
  int m_ptr;
  bit m_busy;
  int m_n;
  int m_addr [MR];
  int m_data [MR];

  typedef struct {
    bit          r;
    logic [15:0] fin;
    int          cnt;
    bit          fl;
    int          fp;
    bit          rdy;
    logic [2:0]  e_we;
    bit          e_v;
    int          e_cnt;
    int          e_ptr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, logic [15:0] fin, int cnt, bit fl, int fp, bit rdy,
                              logic [2:0] e_we, bit e_v, int e_cnt, int e_ptr);
    vec_t v;
    v.r = r; v.fin = fin; v.cnt = cnt; v.fl = fl; v.fp = fp; v.rdy = rdy;
    v.e_we = e_we; v.e_v = e_v; v.e_cnt = e_cnt; v.e_ptr = e_ptr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then advance the model.
  task automatic apply(input bit r, input logic [15:0] fin, input int cnt, input bit fl,
                       input int fp, input bit rdy, input bit has_exp, input logic [2:0] e_we,
                       input bit e_v, input int e_cnt, input int e_ptr);
    logic [MR-1:0]        x_we;
    logic [MR*REG_W-1:0]  x_addr;
    logic [MR*DATA_W-1:0] x_data;
    bit                   x_v;
    int                   x_c;
    bit                   en;
    int                   n;
    rst = r; rob_finished = fin; rob_count = (IDX_W+1)'(cnt);
    flush_valid = fl; flush_ptr = IDX_W'(fp); rf_ready = rdy;
    for (int i = 0; i < ENTRIES; i++) begin
      rob_values[i*DATA_W +: DATA_W] = val[i];
      rob_targets[i*REG_W +: REG_W] = tgt[i];
    end
    @(negedge clk);
    x_we = '0; x_addr = '0; x_data = '0;
    if (m_busy) begin
      for (int k = 0; k < m_n; k++) begin
        x_addr[k*REG_W +: REG_W] = REG_W'(m_addr[k]);
        x_data[k*DATA_W +: DATA_W] = DATA_W'(m_data[k]);
        en = 1'b1;
        for (int k2 = k + 1; k2 < m_n; k2++)
          if (m_addr[k2] == m_addr[k]) en = 1'b0;
        if (!fl && !r) x_we[k] = en;
      end
    end
    x_v = m_busy && rdy && !fl && !r;
    x_c = x_v ? m_n : 0;
    chk("rf_we", 64'(rf_we), 64'(x_we));
    chk("rf_waddr", 64'(rf_waddr), 64'(x_addr));
    chk("rf_wdata", 64'(rf_wdata), 64'(x_data));
    chk("retire_valid", 64'(retire_valid), 64'(x_v));
    chk("retire_count", 64'(retire_count), 64'(x_c));
    chk("retire_ptr", 64'(retire_ptr), 64'(m_ptr));
    if (has_exp) begin
      chk("tbl_we", 64'(rf_we), 64'(e_we));
      chk("tbl_valid", 64'(retire_valid), 64'(e_v));
      chk("tbl_count", 64'(retire_count), 64'(e_cnt));
      chk("tbl_ptr", 64'(retire_ptr), 64'(e_ptr));
    end
    if (r) begin
      m_ptr = 0; m_busy = 1'b0;
    end else if (fl) begin
      m_ptr = fp; m_busy = 1'b0;
    end else if (m_busy) begin
      if (rdy) begin
        m_ptr = (m_ptr + m_n) % ENTRIES;
        m_busy = 1'b0;
      end
    end else begin
      n = 0;
      while (n < MR && n < cnt && fin[(m_ptr + n) % ENTRIES]) n++;
      if (n > 0) begin
        m_busy = 1'b1;
        m_n = n;
        for (int k = 0; k < n; k++) begin
          m_addr[k] = int'(tgt[(m_ptr + k) % ENTRIES]);
          m_data[k] = int'(val[(m_ptr + k) % ENTRIES]);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < ENTRIES; i++) begin
      val[i] = DATA_W'(16'hA000 + i);
      tgt[i] = REG_W'(i);
    end
    tgt[4] = 4'd5;
    tgt[5] = 4'd3;

    // Directed sequences (rst, fin, cnt, flush, fptr, rdy | we, valid, count, ptr).
    tbl.push_back(mk(0, 16'h001F, 5, 0, 0, 1, 3'b000, 0, 0, 0));
    tbl.push_back(mk(0, 16'h001F, 5, 0, 0, 1, 3'b111, 1, 3, 0));
    tbl.push_back(mk(0, 16'h001F, 2, 0, 0, 1, 3'b000, 0, 0, 3));
    tbl.push_back(mk(0, 16'h001F, 2, 0, 0, 1, 3'b011, 1, 2, 3));
    tbl.push_back(mk(0, 16'h001F, 0, 0, 0, 1, 3'b000, 0, 0, 5));
    tbl.push_back(mk(0, 16'h0000, 0, 1, 0, 1, 3'b000, 0, 0, 5));
    tbl.push_back(mk(0, 16'h0005, 3, 0, 0, 1, 3'b000, 0, 0, 0));
    tbl.push_back(mk(0, 16'h0005, 3, 0, 0, 1, 3'b001, 1, 1, 0));
    tbl.push_back(mk(0, 16'h0005, 2, 0, 0, 1, 3'b000, 0, 0, 1));
    tbl.push_back(mk(0, 16'h0005, 2, 0, 0, 1, 3'b000, 0, 0, 1));
    tbl.push_back(mk(0, 16'h0007, 2, 0, 0, 1, 3'b000, 0, 0, 1));
    tbl.push_back(mk(0, 16'h0007, 2, 0, 0, 1, 3'b011, 1, 2, 1));
    tbl.push_back(mk(0, 16'h0000, 0, 1, 14, 1, 3'b000, 0, 0, 3));
    tbl.push_back(mk(0, 16'hC003, 4, 0, 0, 1, 3'b000, 0, 0, 14));
    tbl.push_back(mk(0, 16'hC003, 4, 0, 0, 1, 3'b111, 1, 3, 14));
    tbl.push_back(mk(0, 16'hC003, 1, 0, 0, 1, 3'b000, 0, 0, 1));
    tbl.push_back(mk(0, 16'hC003, 1, 0, 0, 1, 3'b001, 1, 1, 1));
    tbl.push_back(mk(0, 16'h0000, 0, 1, 0, 1, 3'b000, 0, 0, 2));
    tbl.push_back(mk(0, 16'h0007, 3, 0, 0, 0, 3'b000, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 16'h0007, 3, 0, 0, 0, 3'b111, 0, 0, 0));
    tbl.push_back(mk(0, 16'h0007, 3, 0, 0, 1, 3'b111, 1, 3, 0));
    tbl.push_back(mk(0, 16'h0038, 3, 0, 0, 1, 3'b000, 0, 0, 3));
    tbl.push_back(mk(0, 16'h0038, 3, 0, 0, 1, 3'b110, 1, 3, 3));
    tbl.push_back(mk(0, 16'h01C0, 3, 0, 0, 1, 3'b000, 0, 0, 6));
    tbl.push_back(mk(0, 16'h01C0, 3, 1, 9, 1, 3'b000, 0, 0, 6));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 0, 1, 3'b000, 0, 0, 9));
    tbl.push_back(mk(0, 16'h0200, 1, 0, 0, 1, 3'b000, 0, 0, 9));
    tbl.push_back(mk(1, 16'h0200, 1, 1, 9, 1, 3'b000, 0, 0, 9));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 0, 1, 3'b000, 0, 0, 0));
    tbl.push_back(mk(0, 16'hFFFF, 0, 0, 0, 1, 3'b000, 0, 0, 0));
    tbl.push_back(mk(0, 16'hFFFF, 0, 0, 0, 1, 3'b000, 0, 0, 0));

    // Reset.
    rst = 1'b1; rob_finished = '0; rob_values = '0; rob_targets = '0; rob_count = '0;
    flush_valid = 1'b0; flush_ptr = '0; rf_ready = 1'b0;
    m_ptr = 0; m_busy = 1'b0; m_n = 0;
    for (int k = 0; k < MR; k++) begin
      m_addr[k] = 0; m_data[k] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_ptr", 64'(retire_ptr), 64'd0);
    chk("reset_we", 64'(rf_we), 64'd0);
    chk("reset_waddr", 64'(rf_waddr), 64'd0);
    chk("reset_wdata", 64'(rf_wdata), 64'd0);
    chk("reset_valid", 64'(retire_valid), 64'd0);
    chk("reset_count", 64'(retire_count), 64'd0);
    @(posedge clk);
    #1;

    foreach (tbl[i])
      apply(tbl[i].r, tbl[i].fin, tbl[i].cnt, tbl[i].fl, tbl[i].fp, tbl[i].rdy,
            1'b1, tbl[i].e_we, tbl[i].e_v, tbl[i].e_cnt, tbl[i].e_ptr);

    // Random traffic: values change every cycle to exercise capture at scan,
    // narrow target range forces same-register collisions.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < ENTRIES; i++) begin
        val[i] = DATA_W'($urandom);
        tgt[i] = REG_W'($urandom_range(0, 3));
      end
      apply(($urandom_range(0, 99) < 2), 16'($urandom | $urandom),
            int'($urandom_range(0, ENTRIES)), ($urandom_range(0, 99) < 5),
            int'($urandom_range(0, ENTRIES - 1)), ($urandom_range(0, 99) < 70),
            1'b0, 3'b000, 1'b0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rob_commit_ctrl.md
# rob_commit_ctrl

In-order retirement sequencer for the reorder buffer. Each round it scans the oldest ROB entries, selects up to MAX_RETIRE consecutive finished entries and writes their results to the architectural register file through a ready-gated multi-port write interface. It then advances the retire pointer that the ROB uses as its tail. It sits between the ROB status arrays and the register file, and it owns the retire pointer.

## Interface
- ENTRIES, 16, ROB depth (power of two)
- IDX_W, 4, log2(ENTRIES)
- DATA_W, 16, result width
- REG_W, 4, architectural register index width
- MAX_RETIRE, 3, maximum entries retired per round (1..4)
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- rob_finished  in  ENTRIES  finished bit per entry (bit i = entry i)
- rob_values  in  ENTRIES*DATA_W  result per entry (entry i at [i*DATA_W +: DATA_W])
- rob_targets  in  ENTRIES*REG_W  destination register per entry
- rob_count  in  IDX_W+1  allocated, unretired entries (0..ENTRIES)
- flush_valid  in  1  discard the current plan and reload the retire pointer
- flush_ptr  in  IDX_W  new retire pointer on flush
- rf_ready  in  1  register file accepts the write group this cycle
- rf_we  out  MAX_RETIRE  per-port write enable
- rf_waddr  out  MAX_RETIRE*REG_W  per-port register index
- rf_wdata  out  MAX_RETIRE*DATA_W  per-port data
- retire_valid  out  1  group committed this cycle
- retire_count  out  3  entries committed this cycle (0 when retire_valid=0)
- retire_ptr  out  IDX_W  current oldest entry (ROB tail)

## Operation
- Two states: SCAN and COMMIT. Reset state is SCAN with retire_ptr=0 and the plan registers cleared.
- SCAN:
  - Compute n = the number of consecutive set rob_finished bits starting at retire_ptr, indices taken modulo ENTRIES.
  - Clamp n to min(MAX_RETIRE, rob_count).
  - If n=0, stay in SCAN.
  - Otherwise, register the plan and go to COMMIT. The plan holds n plus, for each port k<n, the index retire_ptr+k, rob_targets and rob_values of that entry.
- COMMIT:
  - Drive the registered plan on port k with rf_we[k]=1 for k<n.
  - On a cycle with rf_ready=1: retire_valid=1, retire_count=n, retire_ptr advances by n mod ENTRIES at the edge, next state SCAN.
  - While rf_ready=0, hold all outputs stable and stay in COMMIT.
- Same-register collision within a group: if ports j<k hold the same rf_waddr, clear rf_we[j]. Only the youngest write to a register is enabled. retire_count still counts every entry.
- Port ordering: port 0 always holds the oldest entry, and unused ports have rf_we=0.
- Data is captured at SCAN. Later changes to rob_values for planned entries are ignored.
- Flush:
  - At the edge, retire_ptr=flush_ptr, the plan is discarded and the next state is SCAN.
  - During the flush cycle rf_we=0 and retire_valid=0, even if rf_ready=1 in COMMIT.
- Priority: rst > flush_valid > commit handshake.

## Timing
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, retire_valid=0, retire_count=0, retire_ptr=0.
- rf_we, rf_waddr and rf_wdata come straight from registers.
- retire_valid and retire_count are combinational: they equal state==COMMIT & rf_ready & !flush_valid.
- Minimum latency from a finished bit set at retire_ptr to the write handshake is 2 cycles: the SCAN edge, then COMMIT with rf_ready=1.
- Steady-state throughput is MAX_RETIRE entries per 2 cycles.
- Wrap-around: retire_ptr=ENTRIES-1 with n=3 plans entries ENTRIES-1, 0, 1, and retire_ptr becomes 2.
- Full ROB: rob_count=ENTRIES is legal and is clamped only by MAX_RETIRE.
- Empty ROB: rob_count=0 forces n=0 regardless of stale finished bits.
- Reset asserted in COMMIT:
  - Writes are suppressed in the reset cycle.
  - No retire is reported.
  - retire_ptr returns to 0.

## Test plan
- Reset, then rob_count=5 with entries 0..4 finished and rf_ready=1 every cycle:
  - Cycle 2: retire_count=3, rf_we=3'b111.
  - Cycle 4: retire_count=2, rf_we=3'b011.
  - retire_ptr ends at 5.
- Entries 0 and 2 finished, entry 1 not finished, rob_count=3:
  - n=1 and retire_ptr becomes 1.
  - The controller then stays in SCAN until bit 1 sets.
  - It then retires 1 and 2 together.
- retire_ptr=14, rob_count=4, entries 14, 15, 0, 1 finished:
  - The group is 14, 15, 0 and retire_ptr becomes 1.
  - The next group is entry 1 alone, and retire_ptr becomes 2.
- rf_ready held low for 4 cycles in COMMIT:
  - Outputs stay constant and retire_valid=0 throughout.
  - On the cycle rf_ready rises, a single retire is reported.
- Group targets r3, r5, r3:
  - rf_we=3'b110 (port 0 suppressed) and retire_count=3.
- flush_valid with flush_ptr=9 during COMMIT with rf_ready=1:
  - No write and no retire that cycle.
  - retire_ptr=9 next cycle and the state is SCAN.
  - rst in the same cycle instead gives retire_ptr=0.
